// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and the sequencer state encoding.
// The upstream op decoder imports this package as well.
package alu_pkg;

    localparam int ALU_XLEN    = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the op decoder, alu_seq and the consumer.
interface alu_seq_if #(
    parameter int XLEN = alu_pkg::ALU_XLEN
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter; dout is the accumulator after this cycle's shift.
module alu_shift_iter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dir,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [XLEN-1:0]    din,
    output logic [XLEN-1:0]    dout,
    output logic               last
);

    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_q;
    logic               arith_q;

    // dir_q = 1 shifts left; arith only matters for right shifts
    always_comb begin
        if (dir_q) begin
            dout = {acc[XLEN-2:0], 1'b0};
        end else begin
            dout = {arith_q & acc[XLEN-1], acc[XLEN-1:1]};
        end
    end

    assign last = (cnt == SHAMT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            acc     <= din;
            cnt     <= shamt;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (cnt != '0) begin
            acc <= dout;
            cnt <= cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage: single-cycle logic/arithmetic ops, iterative shifts,
// registered result/zero held until the consumer takes them.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an op
//   SHIFT | iterative shift in progress, one bit per cycle
//   DONE  | result valid, waiting for out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);

    alu_state_e state_q, state_d;

    logic [XLEN-1:0]    comb_res;
    logic [XLEN-1:0]    cap_val;
    logic               cap;
    logic               in_ready;
    logic               out_valid;
    logic [XLEN-1:0]    result_q;
    logic               zero_q;

    logic               sh_load;
    logic               sh_last;
    logic [XLEN-1:0]    sh_dout;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = bus.b[SHAMT_W-1:0];

    // Shift codes fall through to a: that is the shamt == 0 result
    always_comb begin
        comb_res = '0;
        case (bus.alu_op)
            ALU_ADD:  comb_res = bus.a + bus.b;
            ALU_SUB:  comb_res = bus.a - bus.b;
            ALU_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: comb_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            ALU_XOR:  comb_res = bus.a ^ bus.b;
            ALU_OR:   comb_res = bus.a | bus.b;
            ALU_AND:  comb_res = bus.a & bus.b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  comb_res = bus.a;
            default:  comb_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cap       = 1'b0;
        cap_val   = comb_res;
        sh_load   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (is_shift(bus.alu_op) && (shamt != '0)) begin
                        sh_load = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        cap     = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (sh_last) begin
                    cap     = 1'b1;
                    cap_val = sh_dout;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                result_q <= cap_val;
                zero_q   <= (cap_val == '0);
            end
        end
    end

    alu_shift_iter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .dir   (bus.alu_op == ALU_SLL),
        .arith (bus.alu_op == ALU_SRA),
        .shamt (shamt),
        .din   (bus.a),
        .dout  (sh_dout),
        .last  (sh_last)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomised bench for alu_seq with a scoreboard of expected results.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(32)) bus ();

    alu_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] r;
        int          sh;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << sh;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = $unsigned($signed(a) >>> sh);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 32'd0;
        endcase
        e.res = r;
        e.z   = (r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=output expected=no_output", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, bus.result, e.res);
            chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e.z});
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    // Issue one op, scramble inputs after accept, measure latency, then take the result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        int w;
        int lat;
        @(negedge clk);
        drive(op, a, b);
        bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        sb.push_back(model(op, a, b));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.alu_op   = ~op;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        bus.out_ready = 1'b1;
        pop_check(tag);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [11];
        logic [3:0] op;
        logic [31:0] ra, rb;
        int ov_cnt;
        int done;
        int cyc;
        logic took;

        ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);

        run_op("add", 4'b0000, 32'h7FFF_FFFF, 32'd1, 1);
        run_op("sub", 4'b1000, 32'h0000_1234, 32'h0000_1234, 1);
        run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 1);
        run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 1);
        run_op("sll31", 4'b0001, 32'd1, 32'd31, 32);
        run_op("sra4", 4'b1101, 32'h8000_0000, 32'd4, 5);
        run_op("srl4", 4'b0101, 32'h8000_0000, 32'd4, 5);
        run_op("sll_sh0", 4'b0001, 32'hDEAD_BEEF, 32'h0000_0020, 1);
        run_op("sra1", 4'b1101, 32'h8000_0001, 32'hFFFF_FFE1, 2);
        run_op("illegal", 4'b1001, 32'h1234_5678, 32'h0000_0001, 1);

        // Backpressure: hold DONE for 10 cycles with a competing request pending
        @(negedge clk);
        drive(4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        sb.push_back(model(4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F));
        @(posedge clk);
        @(negedge clk);
        drive(4'b0000, 32'd5, 32'd6);
        repeat (10) begin
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_result", bus.result, 32'hFFFF_FFFF);
            chk("bp_zero", {31'd0, bus.zero}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        pop_check("bp");
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_rdy", {31'd0, bus.in_ready}, 32'd1);
        sb.push_back(model(4'b0000, 32'd5, 32'd6));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_next_ov", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        pop_check("bp_next");
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of an sll by 20
        drive(4'b0001, 32'd1, 32'd20);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_zero", {31'd0, bus.zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        ov_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        chk("midrst_no_output", 32'(ov_cnt), 32'd0);
        bus.out_ready = 1'b0;

        // Random traffic with random in_valid gaps and out_ready backpressure
        done = 0;
        cyc  = 0;
        took = 1'b0;
        while (done < 6000 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (took) begin
                bus.in_valid = 1'b0;
                took = 1'b0;
            end
            if (!bus.in_valid && ($urandom % 4 != 0)) begin
                op = ops[$urandom_range(0, 10)];
                ra = $urandom;
                rb = $urandom;
                if ($urandom % 8 == 0) rb = ra;
                if (op == 4'b0001 || op == 4'b0101 || op == 4'b1101) begin
                    if ($urandom % 8 == 0) rb[4:0] = 5'($urandom_range(0, 31));
                    else rb[4:0] = 5'($urandom_range(0, 7));
                end
                drive(op, ra, rb);
            end
            bus.out_ready = ($urandom % 4 != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.alu_op, bus.a, bus.b));
                took = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_check("rand");
                done++;
            end
        end
        chk("rand_done", 32'(done), 32'd6000);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
